dec_key_stream: RTL

Sequential round-key streamer for the decryption path. It latches a 144-bit key and a round range, then emits one 9-bit round key per accepted beat in descending round order over a valid/ready handshake. It sits between key loading and the decryption round datapath. It uses the same word-select/XOR schedule as the combinational key generator, so any beat can be checked against that block.

---
 rtl/dec_key_stream_if.sv | 24 ++
 rtl/dec_key_stream.sv | 129 ++++++++++++
 2 files changed

// File: rtl/dec_key_stream_if.sv
// rtl/dec_key_stream_if.sv - round-key stream bundle between the key streamer and the decryption rounds
interface dec_key_stream_if;
    logic       rk_valid;
    logic       rk_ready;
    logic [8:0] rk_data;
    logic [6:0] rk_idx;
    logic       rk_last;

    modport master (
        output rk_valid,
        output rk_data,
        output rk_idx,
        output rk_last,
        input  rk_ready
    );

    modport slave (
        input  rk_valid,
        input  rk_data,
        input  rk_idx,
        input  rk_last,
        output rk_ready
    );
endinterface

// File: rtl/dec_key_stream.sv
// rtl/dec_key_stream.sv - latches a key and round range, streams round keys in descending round order
module dec_key_stream (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [143:0]           key_in,
    input  logic [6:0]             round_hi,
    input  logic [6:0]             round_lo,
    dec_key_stream_if.master       rk,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [143:0]   key_q, key_d;
    logic [6:0]     lo_q, lo_d;
    logic [6:0]     idx_q, idx_d;
    logic [8:0]     data_q, data_d;
    logic           valid_q, valid_d;
    logic           last_q, last_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           err_q, err_d;
    logic [6:0]     idx_dec;

    // Word select is the 4-bit negation of the low index bits, so i & 15 == 0 maps to word 0.
    function automatic logic [8:0] round_key(input logic [143:0] k, input logic [6:0] i);
        logic [3:0] j;
        j = 4'd0 - i[3:0];
        round_key = k[9*j +: 9] ^ {2'b00, i};
    endfunction

    assign idx_dec = idx_q - 7'd1;

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        lo_d    = lo_q;
        idx_d   = idx_q;
        data_d  = data_q;
        valid_d = valid_q;
        last_d  = last_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (round_hi >= round_lo) begin
                        key_d   = key_in;
                        lo_d    = round_lo;
                        idx_d   = round_hi;
                        data_d  = round_key(key_in, round_hi);
                        last_d  = (round_hi == round_lo);
                        valid_d = 1'b1;
                        busy_d  = 1'b1;
                        state_d = S_RUN;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_RUN: begin
                // idx_q is the current round; it only moves on acceptance, so the beat holds under backpressure.
                if (valid_q && rk.rk_ready) begin
                    if (idx_q == lo_q) begin
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        idx_d  = idx_dec;
                        data_d = round_key(key_q, idx_dec);
                        last_d = (idx_dec == lo_q);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            key_q   <= '0;
            lo_q    <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            lo_q    <= lo_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign rk.rk_valid = valid_q;
    assign rk.rk_data  = data_q;
    assign rk.rk_idx   = idx_q;
    assign rk.rk_last  = last_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;

endmodule
